alu_ins_sequencer: RTL and testbench
====================================

// Module: alu_ins_sequencer
// PURPOSE
//   Issuing end of the register-ALU instruction interface: buffers up to DEPTH 16-bit
//   instructions ({op[15:12], src1[11:8], src2[7:4], dst[3:0]}), drives them on ins and
//   pulses step to walk the datapath through its 3 phases (latch, low half, high half).
//   Captures the two 16-bit result halves from alu_out and reassembles one 32-bit result
//   per instruction. Replaces manual switch/button stepping in the top level.
// PARAMETERS
//   DEPTH   8   instruction buffer entries (power of 2, >=2)
//   SETTLE  2   cycles waited after a step pulse before alu_out is sampled (>=2)
// PORTS
//   clk         in   1   clock
//   rst         in   1   synchronous, active-high reset
//   load_valid  in   1   load_ins valid; accepted when load_ready=1
//   load_ins    in   16  instruction to append to buffer
//   load_ready  out  1   comb: state==IDLE && count<DEPTH
//   clear       in   1   IDLE only: empty buffer (count<=0); ignored when busy
//   start       in   1   IDLE only: execute all buffered instructions in order
//   busy        out  1   1 in any state other than IDLE
//   done        out  1   one-cycle pulse after the last result is emitted
//   ins         out  16  instruction presented to the datapath
//   step        out  1   one-cycle phase-advance strobe to the datapath
//   alu_out     in   16  datapath result half (low after step 1, high after step 2)
//   res_valid   out  1   one-cycle pulse: res_data/res_idx valid
//   res_data    out  32  {high half, low half}
//   res_idx     out  3   buffer index of the instruction (log2 DEPTH bits)
// BEHAVIOUR
//   Reset: count=0, idx=0, state=IDLE; ins=0, step=0, busy=0, done=0, res_valid=0,
//     res_data=0, res_idx=0; load_ready=1 after reset. Buffer contents need not clear.
//   Load: load_valid&&load_ready writes buf[count], count++. At count==DEPTH load_ready=0,
//     extra loads dropped. clear and load same cycle: clear wins, load dropped.
//   start in IDLE with count==0: no run; done pulses next cycle. start while busy: ignored.
//   load+start same cycle in IDLE: load accepted, run covers count+1 instructions.
//   FSM (per instruction idx, 0..count-1):
//     IDLE  -> ISSUE on start (idx<=0).
//     ISSUE : ins<=buf[idx]; step=1 for this cycle (datapath latches ins, goes phase 1)
//             -> W_LO. ins stays stable until next ISSUE.
//     W_LO  : wait SETTLE cycles -> C_LO.
//     C_LO  : lo<=alu_out; step=1 (datapath -> phase 2) -> W_HI.
//     W_HI  : wait SETTLE cycles -> C_HI.
//     C_HI  : res_data<={alu_out,lo}, res_idx<=idx, res_valid=1 next cycle; step=1
//             (datapath -> phase 0) -> NEXT.
//     NEXT  : idx==count-1 -> DONE else idx++ -> ISSUE.
//     DONE  : done=1 one cycle -> IDLE. Buffer retained; start reruns same program.
//   Exactly 3 step pulses per instruction, never on adjacent cycles.
//   Latency per instruction: 2*SETTLE+4 cycles (ISSUE,W_LO*S,C_LO,W_HI*S,C_HI,NEXT).
//   rst mid-run: immediate return to IDLE with reset values; no partial res_valid.
//     Datapath must be reset together (shared rst) to stay phase-aligned.
// TESTING
//   Reset, then load 0x1234 -> load_ready stays 1, count=1; busy=0, step=0, ins=0.
//   Load 1 ins, start, model alu_out=0xBEEF in phase1, 0xCAFE in phase2 -> res_valid
//     once, res_data=0xCAFEBEEF, res_idx=0, exactly 3 step pulses, done 1 cycle later.
//   Fill DEPTH=8 then 9th load -> load_ready=0 on 9th, dropped; run gives 8 results,
//     res_idx 0..7 in order, 8*(2*SETTLE+4) cycles from start to last result.
//   start with empty buffer -> no step, no res_valid, done pulse next cycle.
//   rst asserted during W_HI of instr 2 -> next cycle IDLE, busy=0, no res_valid for
//     instr 2, count=0.
//   Back-to-back with real REG_ALU-style datapath: ADD r1+r2->r3 then reuse r3 -> second
//     result reflects written r3 value.

Source files
------------

// File: rtl/alu_ins_sequencer.sv
// alu_ins_sequencer
//   Issues buffered 16-bit register-ALU instructions to a 3-phase datapath.
//   For each instruction it pulses step three times: latch, low half, high half.
//   It also rebuilds the two 16-bit alu_out halves into one 32-bit result.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   load_valid_i/_ins_i/ready_o  append an instruction while idle
//   clear_i, start_i  idle-only buffer clear / run request
//   busy_o, done_o    run in progress / one-cycle end-of-run pulse
//   ins_o, step_o     instruction and phase-advance strobe to the datapath
//   alu_out_i         datapath result half
//   res_valid_o, res_data_o, res_idx_o  reassembled result per instruction
module alu_ins_sequencer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid_i,
    input  logic [15:0]              load_ins_i,
    output logic                     load_ready_o,
    input  logic                     clear_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [15:0]              ins_o,
    output logic                     step_o,
    input  logic [15:0]              alu_out_i,
    output logic                     res_valid_o,
    output logic [31:0]              res_data_o,
    output logic [$clog2(DEPTH)-1:0] res_idx_o
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned WAIT_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_W_LO,
        S_C_LO,
        S_W_HI,
        S_C_HI,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [15:0]        lo_q;
    logic [15:0]        ins_q;
    logic               step_q;
    logic               busy_q;
    logic               done_q;
    logic               res_valid_q;
    logic [31:0]        res_data_q;
    logic [IDX_W-1:0]   res_idx_q;
    logic [15:0]        buf_q [DEPTH];

    logic               idle_c;
    logic               load_acc_c;
    logic [CNT_W-1:0]   run_cnt_c;
    logic               last_c;

    // Clear beats a same-cycle load; a same-cycle start sees the updated count.
    assign idle_c       = (state_q == S_IDLE);
    assign load_ready_o = idle_c && (count_q < CNT_W'(DEPTH));
    assign load_acc_c   = load_valid_i && load_ready_o && !clear_i;
    assign run_cnt_c    = clear_i ? '0 : count_q + CNT_W'(load_acc_c);
    assign last_c       = (CNT_W'(idx_q) == count_q - CNT_W'(1));

    // Instruction buffer storage, no reset needed
    always_ff @(posedge clk) begin
        if (load_acc_c) begin
            buf_q[count_q[IDX_W-1:0]] <= load_ins_i;
        end
    end

    // Sequencer FSM with registered datapath-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            lo_q        <= '0;
            ins_q       <= '0;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;

            if (idle_c && clear_i) begin
                count_q <= '0;
            end else if (load_acc_c) begin
                count_q <= count_q + CNT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        idx_q  <= '0;
                        if (run_cnt_c == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            step_q  <= 1'b1;
                            // Entry 0 may be written on this very edge
                            ins_q   <= (count_q == '0) ? load_ins_i : buf_q[0];
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_W_LO;
                    wait_q  <= '0;
                end
                S_W_LO: begin
                    if (wait_q == WAIT_W'(SETTLE - 1)) begin
                        state_q <= S_C_LO;
                        step_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_C_LO: begin
                    lo_q    <= alu_out_i;
                    state_q <= S_W_HI;
                    wait_q  <= '0;
                end
                S_W_HI: begin
                    if (wait_q == WAIT_W'(SETTLE - 1)) begin
                        state_q <= S_C_HI;
                        step_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_C_HI: begin
                    res_data_q  <= {alu_out_i, lo_q};
                    res_idx_q   <= idx_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_NEXT;
                end
                S_NEXT: begin
                    if (last_c) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        ins_q   <= buf_q[idx_q + IDX_W'(1)];
                        step_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ins_o       = ins_q;
    assign step_o      = step_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_idx_o   = res_idx_q;

endmodule

// File: tb/tb_alu_ins_sequencer.sv
// Bench for alu_ins_sequencer: a 3-phase register-file datapath sits on the
// issue port, and an architectural model predicts every 32-bit result.
module tb_alu_ins_sequencer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned LAT    = 2 * SETTLE + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_ins = 16'h0;
    logic        load_ready;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] ins;
    logic        step;
    logic [15:0] alu_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic [2:0]  res_idx;

    always #5 clk = ~clk;

    alu_ins_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid_i (load_valid),
        .load_ins_i   (load_ins),
        .load_ready_o (load_ready),
        .clear_i      (clear),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .ins_o        (ins),
        .step_o       (step),
        .alu_out_i    (alu_out),
        .res_valid_o  (res_valid),
        .res_data_o   (res_data),
        .res_idx_o    (res_idx)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ALU semantics shared by the datapath stand-in and the architectural model
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            4'h0:    return {16'h0, a} + {16'h0, b};
            4'h1:    return {16'h0, a} * {16'h0, b};
            4'h2:    return {a ^ b, a & b};
            default: return {b, a};
        endcase
    endfunction

    function automatic logic [15:0] reg_init(input int i);
        return 16'(16'h0101 * i + 3);
    endfunction

    // Datapath stand-in: latch on step 1, low half then high half, write back on step 3
    logic [15:0] dp_r [16];
    logic [1:0]  dp_phase;
    logic [31:0] dp_res;
    logic [3:0]  dp_dst;
    bit          force_mode = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            dp_phase <= 2'd0;
            dp_res   <= '0;
            dp_dst   <= '0;
            for (int i = 0; i < 16; i++) dp_r[i] <= reg_init(i);
        end else if (step) begin
            case (dp_phase)
                2'd0: begin
                    dp_res   <= alu_f(ins[15:12], dp_r[ins[11:8]], dp_r[ins[7:4]]);
                    dp_dst   <= ins[3:0];
                    dp_phase <= 2'd1;
                end
                2'd1:    dp_phase <= 2'd2;
                default: begin
                    dp_r[dp_dst] <= dp_res[15:0];
                    dp_phase     <= 2'd0;
                end
            endcase
        end
    end

    assign alu_out = force_mode ? ((dp_phase == 2'd1) ? 16'hBEEF : 16'hCAFE)
                                : ((dp_phase == 2'd2) ? dp_res[31:16] : dp_res[15:0]);

    // Architectural model: list of accepted instructions plus a register file
    logic [15:0] prog [$];
    logic [15:0] mr [16];
    logic [31:0] exp_q [$];

    task automatic model_reset();
        prog.delete();
        for (int i = 0; i < 16; i++) mr[i] = reg_init(i);
    endtask

    task automatic model_run();
        logic [31:0] r;
        exp_q.delete();
        foreach (prog[i]) begin
            r = alu_f(prog[i][15:12], mr[prog[i][11:8]], mr[prog[i][7:4]]);
            mr[prog[i][3:0]] = r[15:0];
            exp_q.push_back(force_mode ? 32'hCAFEBEEF : r);
        end
    endtask

    // Output monitor, sampled on the falling edge
    int          cyc = 0;
    int          step_cnt = 0;
    int          adj_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    bit          prev_step = 1'b0;
    logic [2:0]  obs_idx [$];
    logic [31:0] obs_data [$];
    int          obs_cyc [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (step) begin
            step_cnt++;
            if (prev_step) adj_cnt++;
        end
        prev_step = step;
        if (res_valid) begin
            obs_idx.push_back(res_idx);
            obs_data.push_back(res_data);
            obs_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic mon_clear();
        step_cnt = 0;
        adj_cnt  = 0;
        done_cnt = 0;
        done_cyc = 0;
        obs_idx.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ins"}, ins, 32'h0);
        check({tag, "_step"}, step, 32'h0);
        check({tag, "_busy"}, busy, 32'h0);
        check({tag, "_done"}, done, 32'h0);
        check({tag, "_res_valid"}, res_valid, 32'h0);
        check({tag, "_res_data"}, res_data, 32'h0);
        check({tag, "_res_idx"}, res_idx, 32'h0);
        check({tag, "_load_ready"}, load_ready, 32'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_vals("reset");
    endtask

    // Called on a falling edge; leaves on the next falling edge
    task automatic drive_load(input logic lv, input logic [15:0] li, input logic clr);
        load_valid = lv;
        load_ins   = li;
        clear      = clr;
        #1;
        check("load_ready", load_ready, (prog.size() < DEPTH));
        if (clr) prog.delete();
        else if (lv && prog.size() < DEPTH) prog.push_back(li);
        @(negedge clk);
        load_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic run_prog(input string tag, input bit poke, input bit co_load,
                            input logic [15:0] co_ins);
        int c0;
        int n;
        bit seen;
        if (co_load && prog.size() < DEPTH) prog.push_back(co_ins);
        model_run();
        n = exp_q.size();
        mon_clear();
        start      = 1'b1;
        load_valid = co_load;
        load_ins   = co_ins;
        c0         = cyc;
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b0;
        check({tag, "_busy_run"}, busy, 32'h1);
        seen = done;
        for (int k = 0; k < n * LAT + 40 && !seen; k++) begin
            start = poke && (k == 3);
            clear = poke && (k == 3);
            @(negedge clk);
            seen = done;
        end
        start = 1'b0;
        clear = 1'b0;
        check({tag, "_done_seen"}, seen, 32'h1);
        @(negedge clk);
        check({tag, "_busy_end"}, busy, 32'h0);
        check({tag, "_n_results"}, obs_data.size(), n);
        for (int i = 0; i < n && i < obs_data.size(); i++) begin
            check({tag, "_res_idx"}, obs_idx[i], i);
            check({tag, "_res_data"}, obs_data[i], exp_q[i]);
            check({tag, "_res_cycle"}, obs_cyc[i] - c0, (i + 1) * LAT);
        end
        check({tag, "_steps"}, step_cnt, 3 * n);
        check({tag, "_adjacent_steps"}, adj_cnt, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc - c0, n * LAT + 1);
        if (n > 0) check({tag, "_ins_hold"}, ins, prog[n-1]);
    endtask

    function automatic logic [15:0] rand_ins();
        logic [3:0] op;
        op = 4'($urandom_range(0, 3));
        return {op, 12'($urandom)};
    endfunction

    typedef struct {
        logic        lv;
        logic [15:0] li;
        logic        clr;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int nr;

        vecs[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 16'h0123, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 16'h1456, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 16'h2789, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 16'h3abc, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'h0def, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'h1111, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 16'h2222, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 16'h3333, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 16'h0444, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 16'h0555, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 16'h1567, 1'b0, 1'b1};

        do_reset();

        // Single load leaves the issue port quiet
        drive_load(1'b1, 16'h1234, 1'b0);
        check("load1_busy", busy, 32'h0);
        check("load1_step", step, 32'h0);
        check("load1_ins", ins, 32'h0);

        // Forced halves: BEEF then CAFE
        force_mode = 1'b1;
        run_prog("forced", 1'b0, 1'b0, 16'h0);
        force_mode = 1'b0;

        // Load/clear/overflow table; only the entry after clear+load survives
        foreach (vecs[i]) begin
            load_valid = vecs[i].lv;
            load_ins   = vecs[i].li;
            clear      = vecs[i].clr;
            #1;
            check("vec_load_ready", load_ready, vecs[i].exp_ready);
            if (vecs[i].clr) prog.delete();
            else if (vecs[i].lv && prog.size() < DEPTH) prog.push_back(vecs[i].li);
            @(negedge clk);
        end
        load_valid = 1'b0;
        clear      = 1'b0;
        run_prog("table", 1'b0, 1'b0, 16'h0);

        // Empty run
        drive_load(1'b0, 16'h0, 1'b1);
        run_prog("empty", 1'b0, 1'b0, 16'h0);

        // Full buffer, dropped 9th load, start/clear poked mid-run, then rerun
        for (int i = 0; i < DEPTH + 1; i++) drive_load(1'b1, rand_ins(), 1'b0);
        run_prog("full", 1'b1, 1'b0, 16'h0);
        run_prog("rerun", 1'b0, 1'b0, 16'h0);

        // Load and start on the same cycle
        drive_load(1'b0, 16'h0, 1'b1);
        run_prog("co_load", 1'b0, 1'b1, rand_ins());

        // Reset during the first W_HI cycle of instruction 2
        drive_load(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 4; i++) drive_load(1'b1, rand_ins(), 1'b0);
        model_run();
        mon_clear();
        start = 1'b1;
        c0    = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_pre_busy", busy, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", busy, 32'h0);
        check("rst_mid_res_valid", res_valid, 32'h0);
        check("rst_mid_step", step, 32'h0);
        check("rst_mid_load_ready", load_ready, 32'h1);
        rst = 1'b0;
        model_reset();
        repeat (2 * LAT) @(negedge clk);
        check("rst_mid_n_results", obs_data.size(), 2);
        if (obs_data.size() >= 2) begin
            check("rst_mid_res0", obs_data[0], exp_q[0]);
            check("rst_mid_res1", obs_data[1], exp_q[1]);
        end
        check("rst_mid_steps", step_cnt, 8);
        run_prog("after_rst", 1'b0, 1'b0, 16'h0);

        // Dependent ADDs: r3 = r1 + r2, then r4 = r3 + r1
        do_reset();
        drive_load(1'b1, 16'h0123, 1'b0);
        drive_load(1'b1, 16'h0314, 1'b0);
        run_prog("b2b", 1'b0, 1'b0, 16'h0);
        if (obs_data.size() >= 2) begin
            check("b2b_add1_const", obs_data[0], 32'h00000309);
            check("b2b_add2_const", obs_data[1], 32'h0000040D);
        end

        // Randomised programs of random length
        for (int r = 0; r < 4; r++) begin
            drive_load(1'b0, 16'h0, 1'b1);
            nr = $urandom_range(1, DEPTH);
            for (int i = 0; i < nr; i++) drive_load(1'b1, rand_ins(), 1'b0);
            run_prog("random", 1'b0, 1'b0, 16'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
